// File: rtl/if_imm_stage.sv
// Instruction fetch and field-split stage feeding the 16-to-32-bit immediate extender.
// Owns the PC, talks valid/ready to instruction memory, holds each fetched word
// until decode takes it, and tells the extender whether to zero- or sign-extend.
module if_imm_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm_16,
  output logic        ext_signal,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_START,
    S_FETCH,
    S_HOLD,
    S_ERROR
  } state_t;

  // The wait counter trips on the cycle it would reach TIMEOUT, so after
  // TIMEOUT unanswered FETCH cycles the stage is in ERROR.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] inst_word;
  logic [31:0] inst_word_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_next;
  logic [31:0] pc_next;
  logic [31:0] inst_pc_next;
  logic        inst_valid_next;
  logic        imem_req_next;
  logic        ext_signal_next;
  logic        fetch_err_next;

  // Redirect targets are word aligned, so the low two bits never reach the PC.
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];

  // Logical immediates (andi/ori/xori/lui) want zero extension; everything
  // else, including arithmetic, compares, loads/stores and branches, sign-extends.
  function automatic logic wants_zero_ext(input logic [5:0] op);
    case (op)
      6'h0C, 6'h0D, 6'h0E, 6'h0F: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  assign imem_addr = pc;
  assign opcode    = inst_word[31:26];
  assign rs        = inst_word[25:21];
  assign rt        = inst_word[20:16];
  assign rd        = inst_word[15:11];
  assign shamt     = inst_word[10:6];
  assign funct     = inst_word[5:0];
  assign imm_16    = inst_word[15:0];

  // State register; reset lands in START so the first request goes out one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_START;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: PC, held instruction, handshake flags and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
      inst_word  <= 32'h0;
      ext_signal <= 1'b0;
      fetch_err  <= 1'b0;
      wait_cnt   <= 8'h0;
    end else begin
      pc         <= pc_next;
      inst_pc    <= inst_pc_next;
      inst_valid <= inst_valid_next;
      imem_req   <= imem_req_next;
      inst_word  <= inst_word_next;
      ext_signal <= ext_signal_next;
      fetch_err  <= fetch_err_next;
      wait_cnt   <= wait_cnt_next;
    end
  end

  // Next-state and next-register logic; a redirect overrides whatever the
  // current state would have done, including discarding a same-cycle response
  // or a same-cycle decode accept.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    inst_pc_next    = inst_pc;
    inst_valid_next = inst_valid;
    imem_req_next   = imem_req;
    inst_word_next  = inst_word;
    ext_signal_next = ext_signal;
    fetch_err_next  = fetch_err;
    wait_cnt_next   = wait_cnt;

    if (redirect) begin
      pc_next         = {redirect_pc[31:2], 2'b00};
      inst_valid_next = 1'b0;
      wait_cnt_next   = 8'h0;
      imem_req_next   = 1'b1;
      state_next      = S_FETCH;
    end else begin
      case (state)
        S_START: begin
          imem_req_next = 1'b1;
          state_next    = S_FETCH;
        end

        S_FETCH: begin
          if (imem_ready) begin
            inst_word_next  = imem_data;
            ext_signal_next = wants_zero_ext(imem_data[31:26]);
            inst_pc_next    = pc;
            inst_valid_next = 1'b1;
            pc_next         = pc + 32'd4;
            wait_cnt_next   = 8'h0;
            imem_req_next   = 1'b0;
            state_next      = S_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            fetch_err_next  = 1'b1;
            imem_req_next   = 1'b0;
            inst_valid_next = 1'b0;
            wait_cnt_next   = 8'h0;
            state_next      = S_ERROR;
          end else begin
            wait_cnt_next = wait_cnt + 8'd1;
          end
        end

        S_HOLD: begin
          if (id_ready) begin
            inst_valid_next = 1'b0;
            imem_req_next   = 1'b1;
            state_next      = S_FETCH;
          end
        end

        S_ERROR: begin
          imem_req_next   = 1'b0;
          inst_valid_next = 1'b0;
        end

        default: begin
          state_next = S_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_imm_stage.sv
// Bench for if_imm_stage: table of known instruction words, directed corner
// sequences, then random handshakes scored against a transaction-level model.
module tb_if_imm_stage;

  localparam int NTBL = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm_16;
  logic        ext_signal;
  logic        fetch_err;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_pc;
  logic [31:0] w_inst_pc;
  logic        w_inst_valid;
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm_16;
  logic        w_ext_signal;
  logic        w_fetch_err;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        ext;
  } vec_t;

  vec_t tbl [NTBL];
  int   total = 0;
  int   bad   = 0;

  if_imm_stage #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_16(imm_16), .ext_signal(ext_signal), .fetch_err(fetch_err)
  );

  if_imm_stage #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(w_pc), .inst_pc(w_inst_pc), .inst_valid(w_inst_valid),
    .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .funct(w_funct),
    .imm_16(w_imm_16), .ext_signal(w_ext_signal), .fetch_err(w_fetch_err)
  );

  always #5 clk = ~clk;

  // Memory contents away from the table: a hash that favours immediate opcodes.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [5:0]  op;
    h = (a ^ 32'hA5A5_5A5A) * 32'h9E37_79B1;
    case (h[31:28])
      4'd0:    op = 6'h0C;
      4'd1:    op = 6'h0D;
      4'd2:    op = 6'h0E;
      4'd3:    op = 6'h0F;
      4'd4:    op = 6'h08;
      4'd5:    op = 6'h09;
      4'd6:    op = 6'h0A;
      4'd7:    op = 6'h0B;
      4'd8:    op = 6'h23;
      4'd9:    op = 6'h2B;
      4'd10:   op = 6'h04;
      4'd11:   op = 6'h05;
      default: op = h[27:22];
    endcase
    return {op, h[25:0]};
  endfunction

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    if (a < 32'(NTBL * 4)) return tbl[a[5:2]].word;
    return mem_word(a);
  endfunction

  // Zero extension is reserved for the logical-immediate opcode block 0x0C..0x0F.
  function automatic logic exp_ext(input logic [5:0] op);
    return (op >= 6'h0C) && (op <= 6'h0F);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rdy, input logic idr, input logic rdir,
                                input logic [31:0] rpc);
    imem_ready  = rdy;
    id_ready    = idr;
    redirect    = rdir;
    redirect_pc = rpc;
    imem_data   = mem_lookup(imem_addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_pc"}, pc, 32'h0);
    check_output({tag, "_inst_pc"}, inst_pc, 32'h0);
    check_output({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check_output({tag, "_req"}, 32'(imem_req), 32'd0);
    check_output({tag, "_fields"}, {opcode, rs, rt, rd, shamt, funct}, 32'h0);
    check_output({tag, "_imm"}, 32'(imm_16), 32'h0);
    check_output({tag, "_ext"}, 32'(ext_signal), 32'd0);
    check_output({tag, "_err"}, 32'(fetch_err), 32'd0);
    check_output({tag, "_wrap_pc"}, w_pc, 32'hFFFF_FFFC);
  endtask

  task automatic check_inst(input string tag, input logic [31:0] word, input logic [31:0] ipc);
    check_output({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check_output({tag, "_fields"}, {opcode, rs, rt, rd, shamt, funct}, word);
    check_output({tag, "_imm"}, 32'(imm_16), 32'(word[15:0]));
    check_output({tag, "_ext"}, 32'(ext_signal), 32'(exp_ext(word[31:26])));
    check_output({tag, "_inst_pc"}, inst_pc, ipc);
  endtask

  task automatic check_vec(input int k);
    check_inst($sformatf("tbl%0d", k), tbl[k].word, 32'(k * 4));
    check_output($sformatf("tbl%0d_op", k), 32'(opcode), 32'(tbl[k].op));
    check_output($sformatf("tbl%0d_rt", k), 32'(rt), 32'(tbl[k].rt));
    check_output($sformatf("tbl%0d_imm_c", k), 32'(imm_16), 32'(tbl[k].imm));
    check_output($sformatf("tbl%0d_ext_c", k), 32'(ext_signal), 32'(tbl[k].ext));
    check_output($sformatf("tbl%0d_pc", k), pc, 32'((k + 1) * 4));
    check_output($sformatf("tbl%0d_req", k), 32'(imem_req), 32'd0);
  endtask

  // Random handshakes scored by a transaction model: next fetch address,
  // the currently held word and whether decode still owes an accept.
  task automatic run_random(input int cycles);
    logic [31:0] exp_pc;
    logic [31:0] exp_word;
    logic [31:0] exp_ipc;
    logic        exp_valid;
    logic        prev_req;
    logic        rdy;
    logic        idr;
    logic        rdir;
    logic [31:0] rpc;
    int          waitc;
    exp_pc    = 32'h0;
    exp_word  = 32'h0;
    exp_ipc   = 32'h0;
    exp_valid = 1'b0;
    waitc     = 0;
    for (int c = 0; c < cycles; c++) begin
      prev_req = imem_req;
      rdir     = ($urandom_range(0, 19) == 0);
      rpc      = $urandom;
      if (prev_req && waitc >= 10) rdy = 1'b1;
      else rdy = ($urandom_range(0, 9) < 6);
      idr = ($urandom_range(0, 9) < 5);
      apply_stimulus(rdy, idr, rdir, rpc);
      step();
      if (rdir) begin
        exp_pc    = {rpc[31:2], 2'b00};
        exp_valid = 1'b0;
        waitc     = 0;
        check_output("rnd_redir_req", 32'(imem_req), 32'd1);
      end else if (prev_req && rdy) begin
        exp_word  = mem_lookup(exp_pc);
        exp_ipc   = exp_pc;
        exp_pc    = exp_pc + 32'd4;
        exp_valid = 1'b1;
        waitc     = 0;
        check_output("rnd_resp_req", 32'(imem_req), 32'd0);
      end else if (exp_valid && idr) begin
        exp_valid = 1'b0;
        check_output("rnd_accept_req", 32'(imem_req), 32'd1);
      end else if (prev_req) begin
        waitc++;
      end
      check_output("rnd_valid", 32'(inst_valid), 32'(exp_valid));
      check_output("rnd_pc", pc, exp_pc);
      check_output("rnd_addr", imem_addr, exp_pc);
      check_output("rnd_fields", {opcode, rs, rt, rd, shamt, funct}, exp_word);
      check_output("rnd_imm", 32'(imm_16), 32'(exp_word[15:0]));
      check_output("rnd_ext", 32'(ext_signal), 32'(exp_ext(exp_word[31:26])));
      check_output("rnd_err", 32'(fetch_err), 32'd0);
      if (exp_valid) check_output("rnd_inst_pc", inst_pc, exp_ipc);
    end
  endtask

  initial begin
    tbl[0]  = '{32'h3C01_1234, 6'h0F, 5'd1,  16'h1234, 1'b1};
    tbl[1]  = '{32'h2021_FFFF, 6'h08, 5'd1,  16'hFFFF, 1'b0};
    tbl[2]  = '{32'h3021_00FF, 6'h0C, 5'd1,  16'h00FF, 1'b1};
    tbl[3]  = '{32'h34A5_ABCD, 6'h0D, 5'd5,  16'hABCD, 1'b1};
    tbl[4]  = '{32'h3800_0001, 6'h0E, 5'd0,  16'h0001, 1'b1};
    tbl[5]  = '{32'h2442_8000, 6'h09, 5'd2,  16'h8000, 1'b0};
    tbl[6]  = '{32'h8C43_0004, 6'h23, 5'd3,  16'h0004, 1'b0};
    tbl[7]  = '{32'h0085_1020, 6'h00, 5'd5,  16'h1020, 1'b0};
    tbl[8]  = '{32'h1000_FFFE, 6'h04, 5'd0,  16'hFFFE, 1'b0};
    tbl[9]  = '{32'h2C01_0010, 6'h0B, 5'd1,  16'h0010, 1'b0};
    tbl[10] = '{32'h2801_7FFF, 6'h0A, 5'd1,  16'h7FFF, 1'b0};
    tbl[11] = '{32'hAC22_0008, 6'h2B, 5'd2,  16'h0008, 1'b0};
    tbl[12] = '{32'h3FFF_FFFF, 6'h0F, 5'd31, 16'hFFFF, 1'b1};

    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    check_reset("rst");

    // Release reset; the request should appear after the single START cycle.
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check_output("start_req", 32'(imem_req), 32'd1);
    check_output("start_valid", 32'(inst_valid), 32'd0);
    check_output("start_addr", imem_addr, 32'h0);

    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check_vec(0);
    check_output("wrap_pc", w_pc, 32'h0);
    check_output("wrap_inst_pc", w_inst_pc, 32'hFFFF_FFFC);
    check_output("wrap_valid", 32'(w_inst_valid), 32'd1);

    // Decode stalls for five cycles; a stray imem_ready must be ignored.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check_inst("hold", tbl[0].word, 32'h0);
      check_output("hold_req", 32'(imem_req), 32'd0);
      check_output("hold_pc", pc, 32'h4);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check_output("accept_valid", 32'(inst_valid), 32'd0);
    check_output("accept_req", 32'(imem_req), 32'd1);
    check_output("accept_addr", imem_addr, 32'h4);

    // Back-to-back fetches with decode always ready: one instruction every two cycles.
    for (int k = 1; k < NTBL; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step();
      check_vec(k);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step();
      check_output($sformatf("gap%0d_valid", k), 32'(inst_valid), 32'd0);
      check_output($sformatf("gap%0d_req", k), 32'(imem_req), 32'd1);
      check_output($sformatf("gap%0d_addr", k), imem_addr, 32'((k + 1) * 4));
    end

    // Redirect colliding with a response: response discarded, low bits cleared.
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    step();
    check_output("redir_pc", pc, 32'h100);
    check_output("redir_addr", imem_addr, 32'h100);
    check_output("redir_valid", 32'(inst_valid), 32'd0);
    check_output("redir_req", 32'(imem_req), 32'd1);
    check_output("redir_fields", {opcode, rs, rt, rd, shamt, funct}, tbl[NTBL-1].word);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check_inst("redir_fetch", mem_lookup(32'h100), 32'h100);
    check_output("redir_fetch_pc", pc, 32'h104);

    // Redirect in HOLD beats a simultaneous decode accept.
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    step();
    check_output("hold_redir_valid", 32'(inst_valid), 32'd0);
    check_output("hold_redir_req", 32'(imem_req), 32'd1);
    check_output("hold_redir_pc", pc, 32'h200);

    // Memory never answers: fifteen waits are tolerated, the sixteenth trips the error.
    for (int i = 1; i < 16; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      check_output($sformatf("wait%0d_err", i), 32'(fetch_err), 32'd0);
      check_output($sformatf("wait%0d_req", i), 32'(imem_req), 32'd1);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_output("timeout_err", 32'(fetch_err), 32'd1);
    check_output("timeout_req", 32'(imem_req), 32'd0);
    check_output("timeout_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step();
      check_output("err_stay_err", 32'(fetch_err), 32'd1);
      check_output("err_stay_req", 32'(imem_req), 32'd0);
      check_output("err_stay_pc", pc, 32'h200);
      check_output("err_stay_valid", 32'(inst_valid), 32'd0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0300);
    step();
    check_output("err_redir_req", 32'(imem_req), 32'd1);
    check_output("err_redir_err", 32'(fetch_err), 32'd1);
    check_output("err_redir_pc", pc, 32'h300);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check_inst("err_refetch", mem_lookup(32'h300), 32'h300);
    check_output("err_refetch_err", 32'(fetch_err), 32'd1);

    // Back into FETCH, then reset mid-cycle: outputs must clear with no clock edge.
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    check_output("pre_rst_req", 32'(imem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset("async");
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);

    run_random(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
